// File: rtl/logic_cluster_v2_pkg.sv
// Shared sizing helpers for the grain-flex logic cluster: clog2 and config-field widths.
package logic_cluster_v2_pkg;

  localparam int unsigned BEL_INPUT_WIDTH_DEF     = 4;
  localparam int unsigned BELS_DEF                = 4;
  localparam int unsigned CLUSTER_INPUT_WIDTH_DEF = 8;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((32'd1 << i) < v) r = 32'(i + 1);
    end
    return r;
  endfunction

  // Select field width: enough codes for every cluster input plus every BEL feedback.
  function automatic int unsigned sel_width(input int unsigned ciw, input int unsigned bels);
    return clog2(ciw + bels);
  endfunction

  // Per-BEL config: truth table, K select fields, ff_bypass, ff_init.
  function automatic int unsigned bel_cfg_width(input int unsigned k, input int unsigned sel_w);
    return (32'd1 << k) + k * sel_w + 2;
  endfunction

endpackage

// File: rtl/logic_cluster_v2_if.sv
// Config scan and fabric data signals of one logic cluster.
interface logic_cluster_v2_if #(
  parameter int unsigned BELS = 4,
  parameter int unsigned CIW  = 8
) ();
  logic            prog_en;
  logic            prog_in;
  logic            prog_out;
  logic            cfg_valid;
  logic [CIW-1:0]  cluster_in;
  logic [BELS-1:0] cluster_out;

  modport master (
    output prog_en, prog_in, cluster_in,
    input  prog_out, cfg_valid, cluster_out
  );

  modport slave (
    input  prog_en, prog_in, cluster_in,
    output prog_out, cfg_valid, cluster_out
  );
endinterface

// File: rtl/logic_cluster_v2_lut_bel.sv
// One BEL: K input select muxes, a 2^K-entry LUT, an output FF and the bypass mux.
module logic_cluster_v2_lut_bel
  import logic_cluster_v2_pkg::*;
#(
  parameter int unsigned K     = 4,
  parameter int unsigned SEL_W = 4,
  parameter int unsigned SRC_W = 12,
  parameter int unsigned CFG_W = 34
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CFG_W-1:0] cfg_i,
  input  logic [SRC_W-1:0] src_i,
  input  logic             hold_i,
  input  logic             load_init_i,
  output logic             ff_q_o,
  output logic             out_o
);

  localparam int unsigned LUT_BITS = 32'd1 << K;
  localparam int unsigned SEL_OFS  = LUT_BITS;
  localparam int unsigned BYP_BIT  = LUT_BITS + K * SEL_W;
  localparam int unsigned INIT_BIT = BYP_BIT + 1;
  localparam int unsigned PAD_W    = 32'd1 << SEL_W;

  logic [PAD_W-1:0]    src_pad;
  logic [K-1:0]        lut_idx;
  logic [LUT_BITS-1:0] truth;
  logic                lut_out;
  logic                ff_d;
  logic                ff_q;

  // Select codes past the last feedback source land in the zero padding.
  assign src_pad = PAD_W'(src_i);
  assign truth   = cfg_i[LUT_BITS-1:0];

  for (genvar k = 0; k < K; k++) begin : g_sel
    assign lut_idx[k] = src_pad[cfg_i[SEL_OFS + k*SEL_W +: SEL_W]];
  end

  assign lut_out = truth[lut_idx];

  always_comb begin
    ff_d = ff_q;
    if (load_init_i)  ff_d = cfg_i[INIT_BIT];
    else if (!hold_i) ff_d = lut_out;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ff_q <= 1'b0;
    else        ff_q <= ff_d;
  end

  assign ff_q_o = ff_q;
  assign out_o  = cfg_i[BYP_BIT] ? lut_out : ff_q;

endmodule

// File: rtl/logic_cluster_v2.sv
// Logic cluster top: config scan chain with length check, BEL array and output gating.
module logic_cluster_v2
  import logic_cluster_v2_pkg::*;
#(
  parameter int unsigned BEL_INPUT_WIDTH     = BEL_INPUT_WIDTH_DEF,
  parameter int unsigned BELS                = BELS_DEF,
  parameter int unsigned CLUSTER_INPUT_WIDTH = CLUSTER_INPUT_WIDTH_DEF
) (
  input logic               clk,
  input logic               rst_n,
  logic_cluster_v2_if.slave bus
);

  localparam int unsigned CIW       = CLUSTER_INPUT_WIDTH;
  localparam int unsigned SEL_W     = sel_width(CIW, BELS);
  localparam int unsigned BEL_CFG_W = bel_cfg_width(BEL_INPUT_WIDTH, SEL_W);
  localparam int unsigned CFG_BITS  = BELS * BEL_CFG_W;
  localparam int unsigned CNT_W     = clog2(CFG_BITS + 2);

  logic [CFG_BITS-1:0] chain_q, chain_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                prog_en_q;
  logic                cfg_valid_q, cfg_valid_d;
  logic                exit_c;
  logic [BELS-1:0]     ff_vec;
  logic [BELS-1:0]     bel_out;

  assign exit_c = prog_en_q & ~bus.prog_en;

  // Shift, count (saturating one past full so overruns stay visible) and judge length on exit.
  always_comb begin
    chain_d     = chain_q;
    cnt_d       = cnt_q;
    cfg_valid_d = cfg_valid_q;
    if (bus.prog_en) begin
      chain_d     = {chain_q[CFG_BITS-2:0], bus.prog_in};
      cfg_valid_d = 1'b0;
      if (!prog_en_q)                          cnt_d = CNT_W'(1);
      else if (cnt_q != CNT_W'(CFG_BITS + 1)) cnt_d = cnt_q + CNT_W'(1);
    end else if (exit_c) begin
      cfg_valid_d = (cnt_q == CNT_W'(CFG_BITS));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain_q     <= '0;
      cnt_q       <= '0;
      prog_en_q   <= 1'b0;
      cfg_valid_q <= 1'b0;
    end else begin
      chain_q     <= chain_d;
      cnt_q       <= cnt_d;
      prog_en_q   <= bus.prog_en;
      cfg_valid_q <= cfg_valid_d;
    end
  end

  for (genvar b = 0; b < BELS; b++) begin : g_bel
    logic_cluster_v2_lut_bel #(
      .K     (BEL_INPUT_WIDTH),
      .SEL_W (SEL_W),
      .SRC_W (CIW + BELS),
      .CFG_W (BEL_CFG_W)
    ) u_bel (
      .clk         (clk),
      .rst_n       (rst_n),
      .cfg_i       (chain_q[b*BEL_CFG_W +: BEL_CFG_W]),
      .src_i       ({ff_vec, bus.cluster_in}),
      .hold_i      (bus.prog_en),
      .load_init_i (exit_c),
      .ff_q_o      (ff_vec[b]),
      .out_o       (bel_out[b])
    );
  end

  // The chain content is meaningless mid-shift, so fabric outputs are silenced.
  assign bus.cluster_out = bus.prog_en ? '0 : bel_out;
  assign bus.prog_out    = chain_q[CFG_BITS-1];
  assign bus.cfg_valid   = cfg_valid_q & ~bus.prog_en;

endmodule

// File: tb/tb_logic_cluster_v2.sv
// Directed bench for logic_cluster_v2: config load, readback, length check, BEL function.
module tb_logic_cluster_v2;

  localparam int unsigned CFG_BITS = 136;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  logic_cluster_v2_if #(.BELS(4), .CIW(8)) bus ();

  logic_cluster_v2 #(
    .BEL_INPUT_WIDTH     (4),
    .BELS                (4),
    .CLUSTER_INPUT_WIDTH (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [CFG_BITS-1:0] cfg2;

  function automatic logic [33:0] bel_cfg(input logic [15:0] tt, input logic [3:0] s0,
                                          input logic [3:0] s1, input logic [3:0] s2,
                                          input logic [3:0] s3, input logic byp,
                                          input logic init);
    return {init, byp, s3, s2, s1, s0, tt};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic shift_stream(input logic [CFG_BITS-1:0] c);
    for (int i = CFG_BITS - 1; i >= 0; i--) begin
      bus.prog_en = 1'b1;
      bus.prog_in = c[i];
      step();
    end
    bus.prog_en = 1'b0;
    bus.prog_in = 1'b0;
    step();
  endtask

  task automatic shift_n(input int n);
    for (int i = 0; i < n; i++) begin
      bus.prog_en = 1'b1;
      bus.prog_in = i[0];
      step();
    end
    bus.prog_en = 1'b0;
    bus.prog_in = 1'b0;
    step();
  endtask

  task automatic test_reset();
    rst_n          = 1'b0;
    bus.prog_en    = 1'b0;
    bus.prog_in    = 1'b0;
    bus.cluster_in = 8'h00;
    #12;
    checks++; if (bus.cluster_out !== 4'b0000) begin failures++; $display("FAIL reset_out got=%b exp=0000", bus.cluster_out); end
    checks++; if (bus.prog_out !== 1'b0) begin failures++; $display("FAIL reset_prog_out got=%b exp=0", bus.prog_out); end
    checks++; if (bus.cfg_valid !== 1'b0) begin failures++; $display("FAIL reset_cfg_valid got=%b exp=0", bus.cfg_valid); end
    @(negedge clk);
    rst_n = 1'b1;
    bus.cluster_in = 8'hFF;
    step(); step(); step();
    checks++; if (bus.cluster_out !== 4'b0000) begin failures++; $display("FAIL zero_lut_out got=%b exp=0000", bus.cluster_out); end
  endtask

  task automatic test_and_bypass();
    cfg2 = {34'd0, 34'd0, 34'd0, bel_cfg(16'h8888, 4'd0, 4'd1, 4'd0, 4'd0, 1'b1, 1'b0)};
    shift_stream(cfg2);
    checks++; if (bus.cfg_valid !== 1'b1) begin failures++; $display("FAIL and_cfg_valid got=%b exp=1", bus.cfg_valid); end
    bus.cluster_in = 8'h03; #1;
    checks++; if (bus.cluster_out !== 4'b0001) begin failures++; $display("FAIL and_in03 got=%b exp=0001", bus.cluster_out); end
    bus.cluster_in = 8'h01; #1;
    checks++; if (bus.cluster_out !== 4'b0000) begin failures++; $display("FAIL and_in01 got=%b exp=0000", bus.cluster_out); end
    bus.cluster_in = 8'h02; #1;
    checks++; if (bus.cluster_out !== 4'b0000) begin failures++; $display("FAIL and_in02 got=%b exp=0000", bus.cluster_out); end
    step();
  endtask

  task automatic test_readback();
    logic [CFG_BITS-1:0] rb;
    logic [3:0]          out_seen;
    logic                valid_seen;
    rb = '0; out_seen = 4'b0000; valid_seen = 1'b0;
    bus.cluster_in = 8'h03;
    for (int i = CFG_BITS - 1; i >= 0; i--) begin
      bus.prog_en = 1'b1;
      bus.prog_in = 1'b0;
      #1;
      rb[i]      = bus.prog_out;
      out_seen   = out_seen | bus.cluster_out;
      valid_seen = valid_seen | bus.cfg_valid;
      step();
    end
    bus.prog_en = 1'b0;
    step();
    checks++; if (rb !== cfg2) begin failures++; $display("FAIL readback_stream got=%h exp=%h", rb, cfg2); end
    checks++; if (out_seen !== 4'b0000) begin failures++; $display("FAIL readback_out_gated got=%b exp=0000", out_seen); end
    checks++; if (valid_seen !== 1'b0) begin failures++; $display("FAIL readback_valid_low got=%b exp=0", valid_seen); end
    checks++; if (bus.cfg_valid !== 1'b1) begin failures++; $display("FAIL readback_cfg_valid got=%b exp=1", bus.cfg_valid); end
    checks++; if (bus.prog_out !== 1'b0) begin failures++; $display("FAIL readback_chain_zero got=%b exp=0", bus.prog_out); end
  endtask

  task automatic test_feedback_toggle();
    bus.cluster_in = 8'h00;
    shift_stream({34'd0, 34'd0, bel_cfg(16'h5555, 4'd9, 4'd0, 4'd0, 4'd0, 1'b0, 1'b1), 34'd0});
    checks++; if (bus.cluster_out !== 4'b0010) begin failures++; $display("FAIL toggle_init got=%b exp=0010", bus.cluster_out); end
    bus.prog_en = 1'b1; #1;
    checks++; if (bus.cluster_out !== 4'b0000) begin failures++; $display("FAIL freeze_gate got=%b exp=0000", bus.cluster_out); end
    bus.prog_en = 1'b0; #1;
    checks++; if (bus.cluster_out !== 4'b0010) begin failures++; $display("FAIL freeze_release got=%b exp=0010", bus.cluster_out); end
    step();
    checks++; if (bus.cluster_out !== 4'b0000) begin failures++; $display("FAIL toggle_1 got=%b exp=0000", bus.cluster_out); end
    step();
    checks++; if (bus.cluster_out !== 4'b0010) begin failures++; $display("FAIL toggle_2 got=%b exp=0010", bus.cluster_out); end
    step();
    checks++; if (bus.cluster_out !== 4'b0000) begin failures++; $display("FAIL toggle_3 got=%b exp=0000", bus.cluster_out); end
  endtask

  task automatic test_length_check();
    shift_n(100);
    checks++; if (bus.cfg_valid !== 1'b0) begin failures++; $display("FAIL len100 got=%b exp=0", bus.cfg_valid); end
    shift_n(140);
    checks++; if (bus.cfg_valid !== 1'b0) begin failures++; $display("FAIL len140 got=%b exp=0", bus.cfg_valid); end
    shift_n(135);
    checks++; if (bus.cfg_valid !== 1'b0) begin failures++; $display("FAIL len135 got=%b exp=0", bus.cfg_valid); end
    shift_n(137);
    checks++; if (bus.cfg_valid !== 1'b0) begin failures++; $display("FAIL len137 got=%b exp=0", bus.cfg_valid); end
    shift_n(136);
    checks++; if (bus.cfg_valid !== 1'b1) begin failures++; $display("FAIL len136 got=%b exp=1", bus.cfg_valid); end
    step(); step();
    checks++; if (bus.cfg_valid !== 1'b1) begin failures++; $display("FAIL len136_hold got=%b exp=1", bus.cfg_valid); end
  endtask

  task automatic test_reset_mid_shift();
    logic [CFG_BITS-1:0] rb;
    for (int i = 0; i < 50; i++) begin
      bus.prog_en = 1'b1;
      bus.prog_in = 1'b1;
      step();
    end
    rst_n = 1'b0;
    bus.prog_en = 1'b0;
    #1;
    checks++; if (bus.cfg_valid !== 1'b0) begin failures++; $display("FAIL midreset_valid got=%b exp=0", bus.cfg_valid); end
    checks++; if (bus.prog_out !== 1'b0) begin failures++; $display("FAIL midreset_prog_out got=%b exp=0", bus.prog_out); end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    checks++; if (bus.cfg_valid !== 1'b0) begin failures++; $display("FAIL midreset_no_exit got=%b exp=0", bus.cfg_valid); end
    rb = '1;
    for (int i = CFG_BITS - 1; i >= 0; i--) begin
      bus.prog_en = 1'b1;
      bus.prog_in = 1'b0;
      #1;
      rb[i] = bus.prog_out;
      step();
    end
    bus.prog_en = 1'b0;
    step();
    checks++; if (rb !== '0) begin failures++; $display("FAIL midreset_chain got=%h exp=0", rb); end
  endtask

  task automatic test_sel_range();
    shift_stream({bel_cfg(16'hAAAA, 4'd7,  4'd0, 4'd0, 4'd0, 1'b1, 1'b0),
                  bel_cfg(16'hAAAA, 4'd15, 4'd0, 4'd0, 4'd0, 1'b1, 1'b0),
                  34'd0,
                  bel_cfg(16'hAAAA, 4'd12, 4'd0, 4'd0, 4'd0, 1'b1, 1'b0)});
    bus.cluster_in = 8'hFF; #1;
    checks++; if (bus.cluster_out !== 4'b1000) begin failures++; $display("FAIL sel_range_ff got=%b exp=1000", bus.cluster_out); end
    bus.cluster_in = 8'h7F; #1;
    checks++; if (bus.cluster_out !== 4'b0000) begin failures++; $display("FAIL sel_range_7f got=%b exp=0000", bus.cluster_out); end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_and_bypass();
    test_readback();
    test_feedback_toggle();
    test_length_check();
    test_reset_mid_shift();
    test_sel_range();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
